// File: rtl/ddr5_phy_freq_ratio_ctrl.sv
// DDR5 PHY frequency-ratio sequencer.
// Runs the DFI init/freq-change handshake around the ratio SerDes block.
module ddr5_phy_freq_ratio_ctrl #(
  parameter logic [1:0] pINIT_RATIO = 2'b00,
  parameter int unsigned pSETTLE_CYC = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dfi_init_start_i,
  input  logic [1:0] dfi_freq_ratio_req_i,
  output logic       dfi_init_complete_o,
  output logic       ratio_enable_o,
  output logic [1:0] dfi_freq_ratio_o,
  output logic [1:0] phase_o,
  output logic       busy_o,
  output logic       freq_err_o
);

  typedef enum logic [2:0] {
    RST_WAIT,
    RUN,
    DRAIN,
    STOP,
    REFILL,
    ACK
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(pSETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q, en_d;
  logic       cmpl_q, cmpl_d;
  logic [1:0] ratio_q, ratio_d;
  logic [1:0] req_q, req_d;
  logic [1:0] phase_q, phase_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  // Last phase index of a frame for a given ratio.
  function automatic logic [1:0] last_f(input logic [1:0] r);
    logic [1:0] l;
    case (r)
      2'b01:   l = 2'd1;
      2'b10:   l = 2'd3;
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  logic at_last;
  assign at_last = (phase_q == last_f(ratio_q));

  // Next-state, handshake and shadow phase computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    cmpl_d  = cmpl_q;
    ratio_d = ratio_q;
    req_d   = req_q;
    err_d   = err_q;
    phase_d = phase_q;
    if (en_q) begin
      phase_d = at_last ? 2'd0 : phase_q + 2'd1;
    end
    unique case (state_q)
      RST_WAIT: begin
        en_d   = 1'b0;
        cmpl_d = 1'b0;
        if (cnt_q == SETTLE_LAST) begin
          en_d    = 1'b1;
          cmpl_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RUN: begin
        en_d   = 1'b1;
        cmpl_d = 1'b1;
        if (dfi_init_start_i) begin
          if (dfi_freq_ratio_req_i == 2'b11) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else if (dfi_freq_ratio_req_i == ratio_q) begin
            err_d   = 1'b0;
            state_d = ACK;
          end else begin
            req_d   = dfi_freq_ratio_req_i;
            err_d   = 1'b0;
            cmpl_d  = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Stop exactly as the datapath counter wraps to 0.
        if (at_last) begin
          en_d    = 1'b0;
          phase_d = 2'd0;
          ratio_d = req_q;
          cnt_d   = 8'd0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == SETTLE_LAST) begin
          en_d    = 1'b1;
          state_d = REFILL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REFILL: begin
        // One full frame at the new ratio before reporting done.
        if (at_last) begin
          cmpl_d  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!dfi_init_start_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RST_WAIT;
      end
    endcase
    busy_d = (state_d == DRAIN) || (state_d == STOP) ||
             (state_d == REFILL);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RST_WAIT;
      cnt_q   <= 8'd0;
      en_q    <= 1'b0;
      cmpl_q  <= 1'b0;
      ratio_q <= pINIT_RATIO;
      req_q   <= pINIT_RATIO;
      phase_q <= 2'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      cmpl_q  <= cmpl_d;
      ratio_q <= ratio_d;
      req_q   <= req_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign dfi_init_complete_o = cmpl_q;
  assign ratio_enable_o      = en_q;
  assign dfi_freq_ratio_o    = ratio_q;
  assign phase_o             = phase_q;
  assign busy_o              = busy_q;
  assign freq_err_o          = err_q;

endmodule

// File: tb/tb_ddr5_phy_freq_ratio_ctrl.sv
// Directed bench for the DDR5 PHY frequency-ratio sequencer.
// Drives and samples on the falling clock edge.
module tb_ddr5_phy_freq_ratio_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] req;
  logic       cmpl;
  logic       en;
  logic [1:0] ratio;
  logic [1:0] phase;
  logic       busy;
  logic       err;

  int total;
  int bad;

  ddr5_phy_freq_ratio_ctrl #(
    .pINIT_RATIO(2'b00),
    .pSETTLE_CYC(8)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .dfi_init_start_i    (start),
    .dfi_freq_ratio_req_i(req),
    .dfi_init_complete_o (cmpl),
    .ratio_enable_o      (en),
    .dfi_freq_ratio_o    (ratio),
    .phase_o             (phase),
    .busy_o              (busy),
    .freq_err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; req = 2'b00;
    repeat (3) @(negedge clk);
    total++; if (cmpl !== 1'b0) begin bad++; $display("FAIL rst_cmpl got=%b exp=0", cmpl); end
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", en); end
    total++; if (ratio !== 2'b00) begin bad++; $display("FAIL rst_ratio got=%b exp=00", ratio); end
    total++; if (phase !== 2'd0) begin bad++; $display("FAIL rst_phase got=%0d exp=0", phase); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        total++; if (en !== 1'b0 || cmpl !== 1'b0) begin bad++; $display("FAIL settle_low k=%0d got en=%b cmpl=%b exp 0 0", k, en, cmpl); end
      end else begin
        total++; if (en !== 1'b1 || cmpl !== 1'b1) begin bad++; $display("FAIL settle_up k=%0d got en=%b cmpl=%b exp 1 1", k, en, cmpl); end
      end
      total++; if (phase !== 2'd0) begin bad++; $display("FAIL settle_phase k=%0d got=%0d exp=0", k, phase); end
    end
  endtask

  task automatic test_change_00_10();
    start = 1'b1; req = 2'b10;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (cmpl !== 1'b0 || busy !== 1'b1 || en !== 1'b1) begin bad++; $display("FAIL drain_entry got cmpl=%b busy=%b en=%b exp 0 1 1", cmpl, busy, en); end
      end
      if (k >= 2 && k <= 9) begin
        total++; if (en !== 1'b0 || ratio !== 2'b10) begin bad++; $display("FAIL stop k=%0d got en=%b ratio=%b exp 0 10", k, en, ratio); end
      end
      if (k >= 10 && k <= 13) begin
        total++; if (en !== 1'b1 || cmpl !== 1'b0 || phase !== 2'(k - 10)) begin bad++; $display("FAIL refill k=%0d got en=%b cmpl=%b ph=%0d exp 1 0 %0d", k, en, cmpl, phase, k - 10); end
      end
      if (k == 14) begin
        total++; if (cmpl !== 1'b1 || busy !== 1'b0 || phase !== 2'd0) begin bad++; $display("FAIL done got cmpl=%b busy=%b ph=%0d exp 1 0 0", cmpl, busy, phase); end
      end
      if (k == 16) start = 1'b0;
      if (k == 17) begin
        total++; if (cmpl !== 1'b1 || busy !== 1'b0 || phase !== 2'd3) begin bad++; $display("FAIL run_after got cmpl=%b busy=%b ph=%0d exp 1 0 3", cmpl, busy, phase); end
      end
    end
  endtask

  task automatic test_drain_mid_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (phase == 2'd1) found = 1'b1;
      else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL phase1_wait got=%0d exp=1", phase); end
    start = 1'b1; req = 2'b01;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (phase !== 2'd2 || cmpl !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mdrain1 got ph=%0d cmpl=%b busy=%b exp 2 0 1", phase, cmpl, busy); end
      end
      if (k == 2) begin
        total++; if (phase !== 2'd3 || en !== 1'b1 || ratio !== 2'b10) begin bad++; $display("FAIL mdrain2 got ph=%0d en=%b ratio=%b exp 3 1 10", phase, en, ratio); end
      end
      if (k >= 3 && k <= 10) begin
        total++; if (en !== 1'b0 || ratio !== 2'b01 || phase !== 2'd0) begin bad++; $display("FAIL mstop k=%0d got en=%b ratio=%b ph=%0d exp 0 01 0", k, en, ratio, phase); end
      end
      if (k == 11 || k == 12) begin
        total++; if (en !== 1'b1 || cmpl !== 1'b0 || phase !== 2'(k - 11)) begin bad++; $display("FAIL mrefill k=%0d got en=%b cmpl=%b ph=%0d exp 1 0 %0d", k, en, cmpl, phase, k - 11); end
      end
      if (k == 13) begin
        total++; if (cmpl !== 1'b1 || busy !== 1'b0 || phase !== 2'd0) begin bad++; $display("FAIL mdone got cmpl=%b busy=%b ph=%0d exp 1 0 0", cmpl, busy, phase); end
        start = 1'b0;
      end
      if (k == 14) begin
        total++; if (cmpl !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mrun got cmpl=%b busy=%b exp 1 0", cmpl, busy); end
      end
    end
  endtask

  task automatic test_illegal();
    start = 1'b1; req = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (err !== 1'b1 || ratio !== 2'b01 || busy !== 1'b0) begin bad++; $display("FAIL ill_err got err=%b ratio=%b busy=%b exp 1 01 0", err, ratio, busy); end
      end
      total++; if (en !== 1'b1 || cmpl !== 1'b1) begin bad++; $display("FAIL ill_hold k=%0d got en=%b cmpl=%b exp 1 1", k, en, cmpl); end
      if (k == 3) start = 1'b0;
      if (k == 4) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", err); end
      end
    end
  endtask

  task automatic test_same_ratio();
    start = 1'b1; req = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL same_errclr got=%b exp=0", err); end
        req = 2'b00;
      end
      if (k <= 4) begin
        total++; if (busy !== 1'b0 || en !== 1'b1 || cmpl !== 1'b1 || ratio !== 2'b01) begin bad++; $display("FAIL same_hold k=%0d got busy=%b en=%b cmpl=%b ratio=%b exp 0 1 1 01", k, busy, en, cmpl, ratio); end
      end
      if (k == 3) start = 1'b0;
      if (k == 4) start = 1'b1;
      if (k == 5) begin
        total++; if (cmpl !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL same_rerun got cmpl=%b busy=%b exp 0 1", cmpl, busy); end
      end
    end
  endtask

  task automatic test_reset_mid_stop();
    @(negedge clk);
    rst = 1'b0; start = 1'b1; req = 2'b10;
    #1;
    total++; if (ratio !== 2'b00 || en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst2 got ratio=%b en=%b busy=%b exp 00 0 0", ratio, en, busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 8) begin
        total++; if (en !== 1'b1 || cmpl !== 1'b1 || ratio !== 2'b00) begin bad++; $display("FAIL held_run got en=%b cmpl=%b ratio=%b exp 1 1 00", en, cmpl, ratio); end
      end
      if (k == 9) begin
        total++; if (cmpl !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL held_svc got cmpl=%b busy=%b exp 0 1", cmpl, busy); end
      end
      if (k >= 10) begin
        total++; if (en !== 1'b0 || ratio !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL held_stop k=%0d got en=%b ratio=%b busy=%b exp 0 10 1", k, en, ratio, busy); end
      end
    end
    #1 rst = 1'b0;
    #1;
    total++; if (cmpl !== 1'b0 || en !== 1'b0 || ratio !== 2'b00 || phase !== 2'd0 || busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL async_rst got cmpl=%b en=%b ratio=%b ph=%0d busy=%b err=%b exp 0 0 00 0 0 0", cmpl, en, ratio, phase, busy, err);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        total++; if (en !== 1'b0 || cmpl !== 1'b0) begin bad++; $display("FAIL rewait got en=%b cmpl=%b exp 0 0", en, cmpl); end
      end
      if (k == 8) begin
        total++; if (en !== 1'b1 || cmpl !== 1'b1 || ratio !== 2'b00) begin bad++; $display("FAIL rerun got en=%b cmpl=%b ratio=%b exp 1 1 00", en, cmpl, ratio); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_change_00_10();
    test_drain_mid_frame();
    test_illegal();
    test_same_ratio();
    test_reset_mid_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr5_phy_freq_ratio_ctrl.md
Name: ddr5_phy_freq_ratio_ctrl

Overview:
Sequencer for the DDR5 PHY frequency-ratio serializer/deserializer block.
- Owns that block's enable and frequency-ratio inputs.
- Runs the DFI init/frequency-change handshake (dfi_init_start / dfi_init_complete) with the memory controller.
- Stops the phase counter on a frame boundary, applies the new ratio while stopped, then restarts and refills before reporting completion.
- Keeps a shadow phase counter that tracks the datapath counter cycle-for-cycle.

Parameters:
- pINIT_RATIO, 2'b00, ratio applied out of reset (00=1:1, 01=1:2, 10=1:4).
- pSETTLE_CYC, 8, cycles enable is held low around reset and around a ratio change (legal range 1..255).

Ports:
- clk_i  input  1  PHY DFI clock.
- rst_i  input  1  Asynchronous reset, active-low.
- dfi_init_start_i  input  1  Frequency-change request from the controller; level-held until it sees dfi_init_complete_o.
- dfi_freq_ratio_req_i  input  2  Requested ratio, sampled when a request is accepted.
- dfi_init_complete_o  output  1  PHY ready / change done.
- ratio_enable_o  output  1  Drives enable_i of the frequency-ratio block.
- dfi_freq_ratio_o  output  2  Drives dfi_freq_ratio_i of the frequency-ratio block.
- phase_o  output  2  Shadow phase counter value.
- busy_o  output  1  High in DRAIN, STOP and REFILL.
- freq_err_o  output  1  Sticky flag: last request carried illegal ratio 2'b11.

Behaviour:
- All outputs are registered. Reset values: dfi_init_complete_o=0, ratio_enable_o=0, dfi_freq_ratio_o=pINIT_RATIO, phase_o=0, busy_o=0, freq_err_o=0, state=RST_WAIT, settle count=0.
- last(r) is 0 for r=00, 1 for r=01, 3 for r=10.
- Shadow phase counter:
  - When ratio_enable_o=1: phase_o <= (phase_o==last(dfi_freq_ratio_o)) ? 0 : phase_o+1.
  - Otherwise it holds.
- States:
  - RST_WAIT: enable=0, complete=0. Counts pSETTLE_CYC cycles, then sets enable=1 and complete=1 and goes to RUN.
  - RUN: enable=1, complete=1. If dfi_init_start_i=1:
    - req=11: freq_err_o<=1, go to ACK, no other change.
    - req equal to current ratio: freq_err_o<=0, go to ACK (no quiesce).
    - otherwise: latch req, freq_err_o<=0, complete<=0, go to DRAIN.
  - DRAIN: enable=1, complete=0. On the edge where phase_o==last(current ratio):
    - ratio_enable_o<=0, phase_o<=0, dfi_freq_ratio_o<=latched req;
    - clear settle count; go to STOP.
    - The datapath counter wraps to 0 on this same edge and then freezes there.
  - STOP: enable=0, complete=0, new ratio stable. After pSETTLE_CYC cycles: ratio_enable_o<=1, go to REFILL.
  - REFILL: enable=1, complete=0. On the edge where phase_o==last(new ratio): complete<=1, go to ACK. One full new frame has passed.
  - ACK: enable=1, complete=1. Waits for dfi_init_start_i=0, then goes to RUN.
    - This prevents re-triggering on a held request.
    - A new request is accepted only from RUN.
- Latency:
  - 1:1 to 1:4 change from a frame boundary: complete low for 1 (DRAIN) + pSETTLE_CYC + 4 cycles.
  - In general: DRAIN length ≤ old frame length; REFILL length = new frame length.
- dfi_freq_ratio_req_i and dfi_init_start_i are ignored outside RUN/ACK. Changes to req after acceptance have no effect.
- dfi_init_start_i high during RST_WAIT: serviced on the first RUN cycle.
- dfi_init_start_i dropped mid-sequence (DRAIN/STOP/REFILL): the sequence still completes, then ACK exits immediately.
- Reset asserted mid-sequence: immediate return to reset values. dfi_freq_ratio_o reverts to pINIT_RATIO.
- Invariant: dfi_freq_ratio_o changes only on the edge where ratio_enable_o goes 1→0, or on reset.
- Invariant: phase_o never exceeds last(dfi_freq_ratio_o).
- busy_o=1 exactly in DRAIN, STOP and REFILL.
- Settle counter is 8 bits; pSETTLE_CYC=1 gives a single STOP cycle.

Test Plan:
- Reset, pSETTLE_CYC=8, pINIT_RATIO=00 -> enable and complete rise together 8 cycles after rst_i release; phase_o stays 0.
- From RUN at ratio 00, request 10 -> complete low; enable low for exactly 8 cycles with dfi_freq_ratio_o=10 throughout; phase_o then runs 0,1,2,3; complete returns on the edge after phase 3; ACK until start drops.
- At ratio 10 with phase_o=1, request 01 -> DRAIN passes phases 2,3; enable falls at the 3→0 wrap; ratio becomes 01; after 8 cycles REFILL lasts 2 cycles.
- Request 11 -> freq_err_o=1, enable never drops, complete stays 1. A following valid request clears freq_err_o.
- Request equal to current ratio (01) -> no enable drop, busy_o stays 0, ACK then RUN once start falls.
- rst_i asserted during STOP after a 00→10 request -> all outputs return to reset values asynchronously; dfi_freq_ratio_o=00; RST_WAIT sequence repeats.
